ccip_c0tx_arbiter: RTL and testbench

Shares the single CCI-P C0 Tx read-request channel among `NUM_REQ` AFU-side requesters using round-robin arbitration. Throttles on `C0TxAlmFull`, tags each request's `mdata` with the requester ID, and routes C0 Rx read responses back to the owning requester. Sits between the AFU's internal read engines and the CCI-P port monitored by the transaction logger.

---
 rtl/ase_pkg.sv | 34 +++
 rtl/ccip_c0tx_arbiter_if.sv | 33 +++
 rtl/ccip_c0tx_arbiter_rr_arbiter.sv | 30 +++
 rtl/ccip_c0tx_arbiter.sv | 142 ++++++++++++++
 tb/tb_ccip_c0tx_arbiter.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ase_pkg.sv
// Shared CCI-P types and constants for the C0 Tx read-request arbiter.
// Header layouts are trimmed to the fields this block touches; mdata sits in the low 16 bits.
package ase_pkg;

  localparam int CCIP_DATA_WIDTH       = 512;
  localparam int CCIP_C0TX_ARB_MAX_REQ = 8;
  localparam int CCIP_MDATA_WIDTH      = 16;

  typedef struct packed {
    logic [1:0]                  vc_sel;
    logic [1:0]                  rsvd;
    logic [1:0]                  cl_len;
    logic [3:0]                  req_type;
    logic [41:0]                 address;
    logic [CCIP_MDATA_WIDTH-1:0] mdata;
  } TxHdr_t;

  typedef struct packed {
    logic [1:0]                  vc_used;
    logic                        rsvd1;
    logic                        hit_miss;
    logic [1:0]                  rsvd0;
    logic [1:0]                  cl_num;
    logic [3:0]                  resp_type;
    logic [CCIP_MDATA_WIDTH-1:0] mdata;
  } RxHdr_t;

  typedef enum logic [1:0] {
    C0TX_ARB_RESET    = 2'd0,
    C0TX_ARB_RUN      = 2'd1,
    C0TX_ARB_THROTTLE = 2'd2
  } c0tx_arb_state_t;

endpackage

// File: rtl/ccip_c0tx_arbiter_if.sv
// Requester-side and CCI-P-side signals of the C0 Tx arbiter; master is the arbiter's view.
// Requests are valid/grant with a combinational grant; the CCI-P side is valid-only with almost-full.
interface ccip_c0tx_arbiter_if #(parameter int NUM_REQ = 4);
  import ase_pkg::*;

  logic [NUM_REQ-1:0]                req_valid;
  TxHdr_t [NUM_REQ-1:0]              req_hdr;
  logic [NUM_REQ-1:0]                req_grant;
  TxHdr_t                            C0TxHdr;
  logic                              C0TxRdValid;
  logic                              C0TxAlmFull;
  RxHdr_t                            C0RxHdr;
  logic [CCIP_DATA_WIDTH-1:0]        C0RxData;
  logic                              C0RxRdValid;
  logic [NUM_REQ-1:0]                rsp_valid;
  RxHdr_t                            rsp_hdr;
  logic [CCIP_DATA_WIDTH-1:0]        rsp_data;
  logic [NUM_REQ-1:0][31:0]          stat_grant_cnt;
  logic [31:0]                       stat_stall_cnt;

  modport master (
    input  req_valid, req_hdr, C0TxAlmFull, C0RxHdr, C0RxData, C0RxRdValid,
    output req_grant, C0TxHdr, C0TxRdValid, rsp_valid, rsp_hdr, rsp_data,
           stat_grant_cnt, stat_stall_cnt
  );

  modport slave (
    output req_valid, req_hdr, C0TxAlmFull, C0RxHdr, C0RxData, C0RxRdValid,
    input  req_grant, C0TxHdr, C0TxRdValid, rsp_valid, rsp_hdr, rsp_data,
           stat_grant_cnt, stat_stall_cnt
  );

endinterface

// File: rtl/ccip_c0tx_arbiter_rr_arbiter.sv
// Round-robin picker: one-hot grant to the first set req at or after ptr, modulo N; zero when en is low.
// Purely combinational; shared with the C1 channel arbiter.
module rr_arbiter #(
  parameter int  N     = 4,
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  input  logic             en,
  output logic [N-1:0]     grant
);

  logic [PTR_W-1:0] idx;

  // Scan from the farthest candidate back toward ptr so the nearest one is the last to win.
  always_comb begin
    grant = '0;
    idx   = '0;
    if (en) begin
      for (int k = N - 1; k >= 0; k--) begin
        idx = PTR_W'((int'(ptr) + k) % N);
        if (req[idx]) begin
          grant      = '0;
          grant[idx] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ccip_c0tx_arbiter.sv
// Round-robin share of CCI-P C0 Tx among NUM_REQ requesters; 1-cycle request and response latency.
// Grants stop the cycle after C0TxAlmFull is seen; ASE_C0TX_ARB_STATS_EN builds the stat counters.
module ccip_c0tx_arbiter
  import ase_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input logic                 clk,
  input logic                 SoftReset_n,
  ccip_c0tx_arbiter_if.master bus
);

  localparam int ID_W = $clog2(NUM_REQ);

  localparam logic [1:0] ST_RESET    = C0TX_ARB_RESET;
  localparam logic [1:0] ST_RUN      = C0TX_ARB_RUN;
  localparam logic [1:0] ST_THROTTLE = C0TX_ARB_THROTTLE;

  logic [1:0]                 state_q, state_d;
  logic [ID_W-1:0]            rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]            winner;
  logic [NUM_REQ-1:0]         grant;
  logic                       xfer;
  TxHdr_t                     tx_hdr_q, tx_hdr_d;
  logic                       tx_vld_q;
  logic [ID_W-1:0]            rx_id;
  logic [NUM_REQ-1:0]         rsp_vld_q, rsp_vld_d;
  RxHdr_t                     rsp_hdr_q, rsp_hdr_d;
  logic [CCIP_DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET:    state_d = ST_RUN;
      ST_RUN:      if (bus.C0TxAlmFull) state_d = ST_THROTTLE;
      ST_THROTTLE: if (!bus.C0TxAlmFull) state_d = ST_RUN;
      default:     state_d = ST_RESET;
    endcase
  end

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req   (bus.req_valid),
    .ptr   (rr_ptr_q),
    .en    ((state_q == ST_RUN) && SoftReset_n),
    .grant (grant)
  );

  assign bus.req_grant = grant;
  assign xfer          = |(grant & bus.req_valid);

  always_comb begin
    winner = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) winner = ID_W'(i);
    end
  end

  // The requester ID rides in the top mdata bits so responses can find their way home.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    tx_hdr_d = tx_hdr_q;
    if (xfer) begin
      rr_ptr_d                = (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
      tx_hdr_d                = bus.req_hdr[winner];
      tx_hdr_d.mdata[15 -: ID_W] = winner;
    end
  end

  assign rx_id = bus.C0RxHdr.mdata[15 -: ID_W];

  always_comb begin
    rsp_vld_d  = '0;
    rsp_hdr_d  = rsp_hdr_q;
    rsp_data_d = rsp_data_q;
    if (bus.C0RxRdValid) begin
      rsp_hdr_d                  = bus.C0RxHdr;
      rsp_hdr_d.mdata[15 -: ID_W] = '0;
      rsp_data_d                 = bus.C0RxData;
      if (int'(rx_id) < NUM_REQ) rsp_vld_d[rx_id] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!SoftReset_n) begin
      state_q    <= ST_RESET;
      rr_ptr_q   <= '0;
      tx_hdr_q   <= '0;
      tx_vld_q   <= 1'b0;
      rsp_vld_q  <= '0;
      rsp_hdr_q  <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      tx_hdr_q   <= tx_hdr_d;
      tx_vld_q   <= xfer;
      rsp_vld_q  <= rsp_vld_d;
      rsp_hdr_q  <= rsp_hdr_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign bus.C0TxHdr     = tx_hdr_q;
  assign bus.C0TxRdValid = tx_vld_q;
  assign bus.rsp_valid   = rsp_vld_q;
  assign bus.rsp_hdr     = rsp_hdr_q;
  assign bus.rsp_data    = rsp_data_q;

`ifdef ASE_C0TX_ARB_STATS_EN
  logic [NUM_REQ-1:0][31:0] grant_cnt_q, grant_cnt_d;
  logic [31:0]              stall_cnt_q, stall_cnt_d;

  // Saturating counters: a wrapped count would read as an idle requester.
  always_comb begin
    grant_cnt_d = grant_cnt_q;
    stall_cnt_d = stall_cnt_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i] && bus.req_valid[i] && (grant_cnt_q[i] != 32'hFFFF_FFFF))
        grant_cnt_d[i] = grant_cnt_q[i] + 32'd1;
    end
    if ((state_q == ST_THROTTLE) && (|bus.req_valid) && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!SoftReset_n) begin
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stat_grant_cnt = grant_cnt_q;
  assign bus.stat_stall_cnt = stall_cnt_q;
`else
  assign bus.stat_grant_cnt = '0;
  assign bus.stat_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ccip_c0tx_arbiter.sv
// Bench for ccip_c0tx_arbiter (NUM_REQ=4): per-cycle reference model plus directed literal checks.
module tb_ccip_c0tx_arbiter;
  import ase_pkg::*;

  localparam int N = 4;
`ifdef ASE_C0TX_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic SoftReset_n;
  always #5 clk = ~clk;

  ccip_c0tx_arbiter_if #(.NUM_REQ(N)) bus ();
  ccip_c0tx_arbiter #(.NUM_REQ(N)) dut (.clk(clk), .SoftReset_n(SoftReset_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic TxHdr_t mk_hdr(input int i);
    TxHdr_t h;
    h          = '0;
    h.address  = 42'h1000 + 42'(i);
    h.req_type = 4'h4;
    h.mdata    = 16'h00A0 + 16'(i);
    return h;
  endfunction

  // Reference model: mode 0 = in reset, 1 = granting, 2 = throttled.
  int              m_mode = 0;
  int              m_ptr  = 0;
  logic            e_tx_vld = 1'b0;
  TxHdr_t          e_tx_hdr = '0;
  logic [N-1:0]    e_rsp_vld = '0;
  RxHdr_t          e_rsp_hdr = '0;
  logic [511:0]    e_rsp_data = '0;
  logic [31:0]     e_gcnt [N] = '{default: 32'd0};
  logic [31:0]     e_stall = 32'd0;

  always @(negedge clk) begin
    logic [N-1:0] eg;
    int           w;
    int           id;
    eg = '0;
    w  = -1;
    if (SoftReset_n && m_mode == 1) begin
      for (int k = 0; k < N; k++) begin
        if (w < 0 && bus.req_valid[2'((m_ptr + k) % N)]) w = (m_ptr + k) % N;
      end
    end
    if (w >= 0) eg[2'(w)] = 1'b1;

    chk("req_grant", 512'(bus.req_grant), 512'(eg));
    chk("tx_vld", 512'(bus.C0TxRdValid), 512'(e_tx_vld));
    chk("tx_hdr", 512'(bus.C0TxHdr), 512'(e_tx_hdr));
    chk("rsp_vld", 512'(bus.rsp_valid), 512'(e_rsp_vld));
    if (e_rsp_vld != '0) begin
      chk("rsp_hdr", 512'(bus.rsp_hdr), 512'(e_rsp_hdr));
      chk("rsp_data", bus.rsp_data, e_rsp_data);
    end
    for (int i = 0; i < N; i++)
      chk("stat_grant", 512'(bus.stat_grant_cnt[i]), 512'(STATS ? e_gcnt[i] : 32'd0));
    chk("stat_stall", 512'(bus.stat_stall_cnt), 512'(STATS ? e_stall : 32'd0));

    if (!SoftReset_n) begin
      m_mode = 0; m_ptr = 0;
      e_tx_vld = 1'b0; e_tx_hdr = '0;
      e_rsp_vld = '0; e_rsp_hdr = '0; e_rsp_data = '0;
      for (int i = 0; i < N; i++) e_gcnt[i] = 32'd0;
      e_stall = 32'd0;
    end else begin
      e_tx_vld = (w >= 0);
      if (w >= 0) begin
        e_tx_hdr = bus.req_hdr[2'(w)];
        e_tx_hdr.mdata = (e_tx_hdr.mdata & 16'h3FFF) | 16'(w << 14);
        m_ptr = (w + 1) % N;
        if (e_gcnt[w] != 32'hFFFF_FFFF) e_gcnt[w] = e_gcnt[w] + 32'd1;
      end
      if (m_mode == 2 && (|bus.req_valid) && e_stall != 32'hFFFF_FFFF) e_stall = e_stall + 32'd1;
      e_rsp_vld = '0;
      if (bus.C0RxRdValid) begin
        id = int'(bus.C0RxHdr.mdata) >> 14;
        e_rsp_vld[2'(id)] = 1'b1;
        e_rsp_hdr = bus.C0RxHdr;
        e_rsp_hdr.mdata = bus.C0RxHdr.mdata & 16'h3FFF;
        e_rsp_data = bus.C0RxData;
      end
      m_mode = (m_mode == 0) ? 1 : (bus.C0TxAlmFull ? 2 : 1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int           wt;
    int           ng;
    int           vcnt;
    logic [11:0]  g;
    int           exp_rot [5] = '{0, 1, 2, 3, 0};
    logic [511:0] d0, d1;
    d0 = {16{32'hDEAD_0001}};
    d1 = {16{32'h1234_5678}};

    SoftReset_n      = 1'b0;
    bus.req_valid    = '0;
    for (int i = 0; i < N; i++) bus.req_hdr[i] = mk_hdr(i);
    bus.C0TxAlmFull  = 1'b0;
    bus.C0RxHdr      = '0;
    bus.C0RxData     = '0;
    bus.C0RxRdValid  = 1'b0;
    repeat (3) step();
    chk("rst_txvld", 512'(bus.C0TxRdValid), 512'(0));
    chk("rst_txhdr", 512'(bus.C0TxHdr), 512'(0));
    chk("rst_rspvld", 512'(bus.rsp_valid), 512'(0));
    chk("rst_grant", 512'(bus.req_grant), 512'(0));

    // All four requesters valid: rotation 0,1,2,3,0.
    SoftReset_n   = 1'b1;
    bus.req_valid = 4'hF;
    step();
    wt = 0;
    while (bus.C0TxRdValid !== 1'b1 && wt < 20) begin step(); wt++; end
    chk("rot_wait", 512'(wt < 20), 512'(1));
    for (int k = 0; k < 5; k++) begin
      chk("rot_vld", 512'(bus.C0TxRdValid), 512'(1));
      chk("rot_id", 512'(bus.C0TxHdr.mdata[15:14]), 512'(exp_rot[k]));
      step();
    end
    bus.req_valid = '0;
    step();

    // Lone requester 2 twice (second time from ptr 3, wrapping), then all valid picks 3.
    bus.req_valid = 4'b0100; #2;
    chk("only2_grant", 512'(bus.req_grant), 512'(4'b0100));
    step();
    #2;
    chk("wrap2_grant", 512'(bus.req_grant), 512'(4'b0100));
    step();
    bus.req_valid = 4'hF; #2;
    chk("ptr3_grant", 512'(bus.req_grant), 512'(4'b1000));
    step();

    // Almost-full for ten cycles with every requester pending.
    vcnt = 0;
    for (int k = 0; k < 12; k++) begin
      bus.C0TxAlmFull = (k < 10);
      #2;
      g[k] = |bus.req_grant;
      if (k >= 1 && k <= 10) vcnt += int'(bus.C0TxRdValid);
      step();
    end
    bus.C0TxAlmFull = 1'b0;
    ng = 0;
    for (int k = 1; k <= 10; k++) ng += int'(g[k]);
    chk("af_first_grant", 512'(g[0]), 512'(1));
    chk("af_no_grants", 512'(ng), 512'(0));
    chk("af_resume", 512'(g[11]), 512'(1));
    chk("af_issue_le1", 512'(vcnt <= 1), 512'(1));
    #2;
    chk("af_stall_cnt", 512'(bus.stat_stall_cnt), 512'(STATS ? 32'd10 : 32'd0));
    step();

    // Responses back to back alongside ongoing requests.
    bus.C0RxRdValid       = 1'b1;
    bus.C0RxHdr           = '0;
    bus.C0RxHdr.resp_type = 4'h4;
    bus.C0RxHdr.mdata     = 16'hC005;
    bus.C0RxData          = d0;
    step();
    chk("rsp0_vld", 512'(bus.rsp_valid), 512'(4'b1000));
    chk("rsp0_mdata", 512'(bus.rsp_hdr.mdata), 512'(16'h0005));
    chk("rsp0_type", 512'(bus.rsp_hdr.resp_type), 512'(4'h4));
    chk("rsp0_data", bus.rsp_data, d0);
    bus.C0RxHdr.mdata = 16'h4123;
    bus.C0RxData      = d1;
    step();
    chk("rsp1_vld", 512'(bus.rsp_valid), 512'(4'b0010));
    chk("rsp1_mdata", 512'(bus.rsp_hdr.mdata), 512'(16'h0123));
    chk("rsp1_data", bus.rsp_data, d1);
    bus.C0RxRdValid = 1'b0;
    step();
    chk("rsp_idle", 512'(bus.rsp_valid), 512'(0));

    // Reset the cycle after a grant, with a response arriving during reset.
    #2;
    chk("mid_grant", 512'(|bus.req_grant), 512'(1));
    step();
    SoftReset_n       = 1'b0;
    bus.C0RxRdValid   = 1'b1;
    bus.C0RxHdr.mdata = 16'h8007;
    #2;
    chk("rst_mid_grant0", 512'(bus.req_grant), 512'(0));
    step();
    chk("rst_mid_txvld", 512'(bus.C0TxRdValid), 512'(0));
    chk("rst_mid_rspvld", 512'(bus.rsp_valid), 512'(0));
    bus.C0RxRdValid = 1'b0;
    step();
    SoftReset_n = 1'b1;
    step();
    wt = 0;
    while (bus.C0TxRdValid !== 1'b1 && wt < 20) begin step(); wt++; end
    chk("post_rst_wait", 512'(wt < 20), 512'(1));
    chk("post_rst_id0", 512'(bus.C0TxHdr.mdata[15:14]), 512'(0));

    // Saturation of requester 1's grant counter.
    bus.req_valid = '0;
    SoftReset_n   = 1'b0;
    repeat (2) step();
    SoftReset_n = 1'b1;
    repeat (2) step();
`ifdef ASE_C0TX_ARB_STATS_EN
    force dut.grant_cnt_q = {32'd0, 32'd0, 32'hFFFF_FFFE, 32'd0};
    e_gcnt[1] = 32'hFFFF_FFFE;
    #1;
    release dut.grant_cnt_q;
`endif
    bus.req_valid = 4'b0010;
    repeat (3) step();
    bus.req_valid = '0;
    step();
    chk("sat_cnt1", 512'(bus.stat_grant_cnt[1]), 512'(STATS ? 32'hFFFF_FFFF : 32'd0));
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
